adc_decimator: RTL and testbench

ADC_DECIMATOR -- requirements
Module: adc_decimator

---
 rtl/anc_pkg.sv | 16 +
 rtl/adc_decimator_if.sv | 31 +++
 rtl/adc_decimator_dc_tracker.sv | 40 ++++
 rtl/adc_decimator.sv | 129 ++++++++++++
 tb/tb_adc_decimator.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/anc_pkg.sv
// Shared types and constants for the audio front-end: sample format,
// ADC width and the decimator's two-state lock FSM encoding.
package anc_pkg;

    typedef logic signed [15:0] sample_t;

    localparam int ADC_W      = 12;
    localparam int SAMPLE_MAX = 32767;
    localparam int SAMPLE_MIN = -32768;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dec_state_t;

endpackage

// File: rtl/adc_decimator_if.sv
// Conversion input and sample output bundle of the ADC decimator.
// The master side feeds conversions; the slave side is the decimator.
interface adc_decimator_if;
    import anc_pkg::*;

    logic               enable_in;
    logic               adc_valid_in;
    logic [ADC_W-1:0]   adc_data_in;
    logic               ready_out;
    sample_t            x_out;
    logic               locked_out;

    modport master (
        output enable_in,
        output adc_valid_in,
        output adc_data_in,
        input  ready_out,
        input  x_out,
        input  locked_out
    );

    modport slave (
        input  enable_in,
        input  adc_valid_in,
        input  adc_data_in,
        output ready_out,
        output x_out,
        output locked_out
    );

endinterface

// File: rtl/adc_decimator_dc_tracker.sv
// Leaky-integrator DC estimate: holds the estimate with DC_SHIFT fraction
// bits and reports the averaged sample minus the integer part of the estimate.
module dc_tracker
    import anc_pkg::*;
#(
    parameter int DC_SHIFT = 10
)(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    i_load,
    input  logic                    i_update,
    input  logic [ADC_W-1:0]        i_avg,
    output logic signed [ADC_W:0]   o_diff
);

    localparam int DC_W = ADC_W + DC_SHIFT;

    logic [DC_W-1:0]  r_dc_acc;
    logic [ADC_W-1:0] w_dc_int;
    logic [DC_W-1:0]  w_dc_next;

    assign w_dc_int = r_dc_acc[DC_W-1:DC_SHIFT];
    assign o_diff   = $signed({1'b0, i_avg}) - $signed({1'b0, w_dc_int});
    // Modular intermediate is fine: the leak keeps the result below 2^DC_W.
    assign w_dc_next = r_dc_acc + DC_W'(i_avg) - DC_W'(w_dc_int);

    // DC estimate register: seeded on the first block, then leaked per block.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_dc_acc <= '0;
        end else if (i_load) begin
            r_dc_acc <= {i_avg, {DC_SHIFT{1'b0}}};
        end else if (i_update) begin
            r_dc_acc <= w_dc_next;
        end else begin
            r_dc_acc <= r_dc_acc;
        end
    end

endmodule

// File: rtl/adc_decimator.sv
// Block-average decimator for a 12-bit microphone ADC with DC removal,
// gain and saturation to a signed 16-bit sample stream.
module adc_decimator
    import anc_pkg::*;
#(
    parameter int DECIM      = 8,
    parameter int DC_SHIFT   = 10,
    parameter int GAIN_SHIFT = 4
)(
    input logic             clk_in,
    input logic             rst_in,
    adc_decimator_if.slave  bus
);

    localparam int LOG2D = $clog2(DECIM);
    localparam int ACC_W = ADC_W + LOG2D;

    logic [ACC_W-1:0]       r_acc;
    logic [LOG2D-1:0]       r_cnt;
    logic [ADC_W-1:0]       r_avg;
    logic                   r_s1_vld;
    dec_state_t             r_state;
    logic                   r_ready;
    sample_t                r_x;
    logic                   r_locked;

    logic [ACC_W-1:0]       w_sum;
    logic signed [ADC_W:0]  w_diff;
    logic signed [31:0]     w_shifted;
    sample_t                w_sat;
    logic                   w_load;
    logic                   w_update;

    assign w_sum     = r_acc + ACC_W'(bus.adc_data_in);
    assign w_load    = r_s1_vld && (r_state == ST_INIT);
    assign w_update  = r_s1_vld && (r_state == ST_RUN);
    assign w_shifted = $signed({{(31 - ADC_W){w_diff[ADC_W]}}, w_diff}) <<< GAIN_SHIFT;

    // Clamp the gained difference into the 16-bit sample range.
    always_comb begin
        w_sat = '0;
        if (w_shifted > SAMPLE_MAX) begin
            w_sat = sample_t'(SAMPLE_MAX);
        end else if (w_shifted < SAMPLE_MIN) begin
            w_sat = sample_t'(SAMPLE_MIN);
        end else begin
            w_sat = sample_t'(w_shifted[15:0]);
        end
    end

    // Stage 1: accumulate DECIM conversions and register the block average.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_avg    <= '0;
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= 1'b0;
            if (!bus.enable_in) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (bus.adc_valid_in) begin
                if (r_cnt == LOG2D'(DECIM - 1)) begin
                    r_avg    <= w_sum[ACC_W-1:LOG2D];
                    r_s1_vld <= 1'b1;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + LOG2D'(1);
                end
            end else begin
                r_acc <= r_acc;
                r_cnt <= r_cnt;
            end
        end
    end

    dc_tracker #(
        .DC_SHIFT (DC_SHIFT)
    ) u_dc_tracker (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .i_load   (w_load),
        .i_update (w_update),
        .i_avg    (r_avg),
        .o_diff   (w_diff)
    );

    // Stage 2 / lock FSM: first block only seeds the tracker, later blocks emit.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state  <= ST_INIT;
            r_ready  <= 1'b0;
            r_x      <= '0;
            r_locked <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    if (r_s1_vld) begin
                        r_state  <= ST_RUN;
                        r_locked <= 1'b1;
                    end else begin
                        r_state  <= ST_INIT;
                    end
                end
                ST_RUN: begin
                    if (r_s1_vld) begin
                        r_ready <= 1'b1;
                        r_x     <= w_sat;
                    end else begin
                        r_x     <= r_x;
                    end
                end
                default: begin
                    r_state  <= ST_INIT;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_out  = r_ready;
    assign bus.x_out      = r_x;
    assign bus.locked_out = r_locked;

endmodule

// File: tb/tb_adc_decimator.sv
// Self-checking bench for adc_decimator: a block-level reference model is
// compared every cycle, plus directed scenarios with literal expectations.
module tb_adc_decimator;
    import anc_pkg::*;

    localparam int DECIM      = 8;
    localparam int DC_SHIFT   = 10;
    localparam int GAIN_SHIFT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_decimator_if bus();

    adc_decimator #(
        .DECIM      (DECIM),
        .DC_SHIFT   (DC_SHIFT),
        .GAIN_SHIFT (GAIN_SHIFT)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clamp16(input int v);
        if (v > SAMPLE_MAX) return SAMPLE_MAX;
        if (v < SAMPLE_MIN) return SAMPLE_MIN;
        return v;
    endfunction

    // Reference model: collect conversions into blocks, resolve each block two
    // cycles after its last conversion using integer arithmetic.
    typedef struct { int due; int avg; } ev_t;
    ev_t evq[$];
    int  blk[$];
    int  cyc = 0;
    bit  m_locked = 1'b0;
    bit  m_ready  = 1'b0;
    int  m_dc = 0;
    int  m_x  = 0;

    initial begin
        ev_t ev;
        int  dc_int;
        forever begin
            @(posedge clk);
            cyc++;
            m_ready = 1'b0;
            if (rst) begin
                evq.delete();
                blk.delete();
                m_locked = 1'b0;
                m_dc = 0;
                m_x  = 0;
            end else begin
                if (evq.size() > 0 && evq[0].due == cyc) begin
                    ev = evq.pop_front();
                    if (!m_locked) begin
                        m_dc = ev.avg * (2 ** DC_SHIFT);
                        m_locked = 1'b1;
                    end else begin
                        dc_int  = m_dc / (2 ** DC_SHIFT);
                        m_x     = clamp16((ev.avg - dc_int) * (2 ** GAIN_SHIFT));
                        m_dc    = m_dc + ev.avg - dc_int;
                        m_ready = 1'b1;
                    end
                end
                if (!bus.enable_in) begin
                    blk.delete();
                end else if (bus.adc_valid_in) begin
                    blk.push_back(int'(bus.adc_data_in));
                    if (blk.size() == DECIM) begin
                        evq.push_back('{cyc + 1, blk.sum() / DECIM});
                        blk.delete();
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus pulse bookkeeping.
    bit cmp_en = 1'b0;
    int pulses = 0;
    int last_x = 0;
    int pulse_cyc[$];

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("ready_out", int'(bus.ready_out), int'(m_ready));
                chk("x_out", int'($signed(bus.x_out)), m_x);
                chk("locked_out", int'(bus.locked_out), int'(m_locked));
                if (bus.ready_out) begin
                    pulses++;
                    last_x = int'($signed(bus.x_out));
                    pulse_cyc.push_back(cyc);
                end
            end
        end
    end

    int last_drive_cyc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.adc_valid_in = 1'b0;
        bus.enable_in    = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input int n, input int v);
        for (int i = 0; i < n; i++) begin
            bus.enable_in    = 1'b1;
            bus.adc_valid_in = 1'b1;
            bus.adc_data_in  = 12'(v);
            last_drive_cyc   = cyc;
            tick();
        end
        bus.adc_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.adc_valid_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int p0;
        int q0;
        bus.enable_in    = 1'b0;
        bus.adc_valid_in = 1'b0;
        bus.adc_data_in  = 12'd0;
        tick();
        cmp_en = 1'b1;
        tick();
        chk("reset_ready", int'(bus.ready_out), 0);
        chk("reset_x", int'($signed(bus.x_out)), 0);
        chk("reset_locked", int'(bus.locked_out), 0);
        rst = 1'b0;

        // Lock on the first block, first real sample two cycles after block end.
        p0 = pulses;
        send(8, 1775);
        idle(3);
        chk("init_no_pulse", pulses - p0, 0);
        chk("init_locked", int'(bus.locked_out), 1);
        send(8, 1775);
        idle(3);
        chk("first_pulse_count", pulses - p0, 1);
        chk("first_x", last_x, 0);
        chk("first_latency", pulse_cyc[$] - last_drive_cyc, 2);

        send(8, 1875);
        idle(3);
        chk("step_up_x", last_x, 1600);
        send(8, 1775);
        idle(3);
        chk("step_back_x", last_x, 0);

        send(8, 4095);
        idle(3);
        chk("sat_pos_x", last_x, 32767);
        do_reset();
        send(8, 4095);
        send(8, 0);
        idle(3);
        chk("sat_neg_x", last_x, -32768);

        // Back-to-back blocks: pulses every DECIM cycles.
        do_reset();
        send(8, 1775);
        p0 = pulses;
        q0 = pulse_cyc.size();
        for (int i = 0; i < 64; i++) send(1, 1700 + int'($urandom_range(0, 150)));
        idle(3);
        chk("b2b_pulses", pulses - p0, 8);
        if (pulses - p0 == 8) begin
            for (int i = 1; i < 8; i++)
                chk("b2b_spacing", pulse_cyc[q0 + i] - pulse_cyc[q0 + i - 1], 8);
        end

        // Disable discards the partial block, valids while disabled ignored.
        do_reset();
        send(8, 1775);
        idle(3);
        p0 = pulses;
        send(3, 500);
        bus.enable_in    = 1'b0;
        bus.adc_valid_in = 1'b1;
        bus.adc_data_in  = 12'd4095;
        tick();
        tick();
        send(8, 1800);
        idle(3);
        chk("disable_pulses", pulses - p0, 1);
        chk("disable_x", last_x, 400);

        // Reset mid-block discards the partial data.
        do_reset();
        send(5, 1234);
        do_reset();
        p0 = pulses;
        send(8, 1000);
        idle(3);
        chk("midrst_pulses", pulses - p0, 0);
        chk("midrst_locked", int'(bus.locked_out), 1);
        chk("midrst_x", int'($signed(bus.x_out)), 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst              = ($urandom_range(0, 599) == 0);
            bus.enable_in    = ($urandom_range(0, 19) != 0);
            bus.adc_valid_in = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0)
                bus.adc_data_in = 12'($urandom_range(0, 4095));
            else
                bus.adc_data_in = 12'($urandom_range(1600, 2400));
            tick();
        end
        rst = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
